branch_predictor: RTL and testbench

- Parametrised branch target buffer (BTB) with per-entry saturating direction counters.
- Consulted combinationally by fetch every cycle with the current word PC; returns hit, predicted direction and predicted target.
- Trained by the decode stage, where branches/jumps resolve; flags mispredictions so the fetch/decode pipe register can be flushed.
- Keeps saturating statistics counters for branches resolved and mispredictions.

---
 rtl/branch_predictor_pkg.sv | 25 ++
 rtl/branch_predictor_sat_ctr.sv | 39 +++
 rtl/branch_predictor.sv | 131 +++++++++++++
 tb/tb_branch_predictor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the direct-mapped BTB with saturating direction counters.
package bp_types_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    localparam int unsigned DEF_PC_W    = 30;
    localparam int unsigned DEF_ENTRIES = 16;
    localparam int unsigned DEF_CTR_W   = 2;
    localparam int unsigned DEF_STAT_W  = 32;

    // Weakly-taken is the counter midpoint; weakly-not-taken sits just below it.
    function automatic int unsigned ctr_weak_t(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic int unsigned ctr_weak_nt(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// Saturating up/down counter with synchronous load; shared by direction and statistics counters.
module sat_ctr #(
    parameter int unsigned     W       = 2,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer: combinational lookup for fetch, training and
// misprediction detection for decode, plus saturating resolved/mispredict statistics.
module branch_predictor
    import bp_types_pkg::*;
#(
    parameter int unsigned PC_W    = DEF_PC_W,
    parameter int unsigned ENTRIES = DEF_ENTRIES,
    parameter int unsigned CTR_W   = DEF_CTR_W,
    parameter int unsigned STAT_W  = DEF_STAT_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [PC_W-1:0]   lk_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic              upd_en,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_target,
    output logic              mispredict,
    input  logic              inval,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_t(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_nt(CTR_W));

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [PC_W-1:0]   target;
    } btb_entry_t;

    function automatic logic [IDX_W-1:0] pc_idx(input logic [PC_W-1:0] pc);
        return pc[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_W-1:0] pc);
        return pc[PC_W-1:IDX_W];
    endfunction

    btb_entry_t        btb_q [ENTRIES];
    btb_entry_t        btb_d [ENTRIES];
    logic [CTR_W-1:0]  ctr   [ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic              upd_fire;
    logic              upd_write;

    assign lk_idx      = pc_idx(lk_pc);
    assign pred_hit    = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == pc_tag(lk_pc));
    assign pred_taken  = pred_hit && ctr[lk_idx][CTR_W-1];
    assign pred_target = pred_hit ? btb_q[lk_idx].target : lk_pc + PC_W'(1);

    assign upd_idx   = pc_idx(upd_pc);
    assign upd_tag   = pc_tag(upd_pc);
    assign upd_hit   = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == upd_tag);
    assign upd_fire  = upd_valid && upd_en;
    // Statistics follow upd_fire, but entry training is suppressed by a same-cycle inval.
    assign upd_write = upd_fire && !inval;

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    always_comb begin
        btb_d = btb_q;
        if (inval) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_d[i].valid = 1'b0;
            end
        end else if (upd_write && upd_taken) begin
            btb_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, target: upd_target};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '0;
            end
        end else begin
            btb_q <= btb_d;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic sel;
        assign sel = upd_write && (upd_idx == IDX_W'(g));
        sat_ctr #(.W(CTR_W), .RST_VAL(CTR_WNT)) u_ctr (
            .CLK      (CLK),
            .nRST     (nRST),
            .inc      (sel && upd_hit && upd_taken),
            .dec      (sel && upd_hit && !upd_taken),
            .load     (sel && !upd_hit && upd_taken),
            .load_val (CTR_WT),
            .q        (ctr[g])
        );
    end

    sat_ctr #(.W(STAT_W), .RST_VAL('0)) u_stat_branches (
        .CLK      (CLK),
        .nRST     (nRST),
        .inc      (upd_fire),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .q        (stat_branches)
    );

    sat_ctr #(.W(STAT_W), .RST_VAL('0)) u_stat_mispred (
        .CLK      (CLK),
        .nRST     (nRST),
        .inc      (upd_fire && mispredict),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .q        (stat_mispred)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with 4-bit statistics so saturation is reachable.
module tb_branch_predictor;

    localparam int unsigned PC_W   = 30;
    localparam int unsigned STAT_W = 4;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic [PC_W-1:0]   lk_pc = '0;
    logic              pred_hit;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              upd_valid = 1'b0;
    logic              upd_en = 1'b0;
    logic [PC_W-1:0]   upd_pc = '0;
    logic              upd_taken = 1'b0;
    logic [PC_W-1:0]   upd_target = '0;
    logic              upd_pred_taken = 1'b0;
    logic [PC_W-1:0]   upd_pred_target = '0;
    logic              mispredict;
    logic              inval = 1'b0;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispred;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    branch_predictor #(.PC_W(PC_W), .ENTRIES(16), .CTR_W(2), .STAT_W(STAT_W)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .lk_pc           (lk_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_en          (upd_en),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .inval           (inval),
        .stat_branches   (stat_branches),
        .stat_mispred    (stat_mispred)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [PC_W-1:0] pc,
                          input logic hit, input logic tk, input logic [PC_W-1:0] tgt);
        lk_pc = pc;
        #1;
        check({tag, ".hit"}, 64'(pred_hit), 64'(hit));
        check({tag, ".taken"}, 64'(pred_taken), 64'(tk));
        check({tag, ".target"}, 64'(pred_target), 64'(tgt));
    endtask

    task automatic stats(input string tag, input int unsigned br, input int unsigned mp);
        check({tag, ".branches"}, 64'(stat_branches), 64'(br));
        check({tag, ".mispred"}, 64'(stat_mispred), 64'(mp));
    endtask

    // One qualified update: drive, check the combinational mispredict, clock it in.
    task automatic update(input string tag, input logic [PC_W-1:0] pc, input logic tk,
                          input logic [PC_W-1:0] tgt, input logic ptk,
                          input logic [PC_W-1:0] ptgt, input logic exp_mp);
        upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_pred_taken = ptk; upd_pred_target = ptgt;
        upd_valid = 1'b1; upd_en = 1'b1;
        #1;
        check({tag, ".mispredict"}, 64'(mispredict), 64'(exp_mp));
        tick();
        upd_valid = 1'b0; upd_en = 1'b0;
        #1;
    endtask

    initial begin
        tick(); tick();
        nRST = 1'b1;
        tick();

        lookup("cold", 30'h10, 1'b0, 1'b0, 30'h11);
        stats("cold", 0, 0);

        update("alloc", 30'h10, 1'b1, 30'h40, 1'b0, 30'h0, 1'b1);
        lookup("alloc", 30'h10, 1'b1, 1'b1, 30'h40);
        stats("alloc", 1, 1);

        update("nt1", 30'h10, 1'b0, 30'h0, 1'b1, 30'h40, 1'b1);
        lookup("nt1", 30'h10, 1'b1, 1'b0, 30'h40);
        update("nt2", 30'h10, 1'b0, 30'h0, 1'b1, 30'h40, 1'b1);
        update("nt3", 30'h10, 1'b0, 30'h0, 1'b1, 30'h40, 1'b1);
        stats("nt3", 4, 4);

        // From saturated 00 the first taken update only reaches 01.
        update("t1", 30'h10, 1'b1, 30'h40, 1'b1, 30'h40, 1'b0);
        lookup("t1", 30'h10, 1'b1, 1'b0, 30'h40);
        update("t2", 30'h10, 1'b1, 30'h40, 1'b1, 30'h40, 1'b0);
        lookup("t2", 30'h10, 1'b1, 1'b1, 30'h40);
        update("t3", 30'h10, 1'b1, 30'h40, 1'b1, 30'h40, 1'b0);
        update("t4", 30'h10, 1'b1, 30'h40, 1'b1, 30'h40, 1'b0);
        stats("t4", 8, 4);
        // Saturated at 11, so one not-taken still predicts taken.
        update("nt_sat", 30'h10, 1'b0, 30'h0, 1'b1, 30'h40, 1'b1);
        lookup("nt_sat", 30'h10, 1'b1, 1'b1, 30'h40);

        update("retarget", 30'h10, 1'b1, 30'h44, 1'b1, 30'h40, 1'b1);
        lookup("retarget", 30'h10, 1'b1, 1'b1, 30'h44);
        stats("retarget", 10, 6);

        update("alias", 30'h20, 1'b1, 30'h80, 1'b0, 30'h0, 1'b1);
        lookup("alias_old", 30'h10, 1'b0, 1'b0, 30'h11);
        lookup("alias_new", 30'h20, 1'b1, 1'b1, 30'h80);

        update("miss_nt", 30'h30, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0);
        lookup("miss_nt", 30'h30, 1'b0, 1'b0, 30'h31);
        lookup("miss_nt_keep", 30'h20, 1'b1, 1'b1, 30'h80);
        stats("miss_nt", 12, 7);

        upd_pc = 30'h05; upd_taken = 1'b1; upd_target = 30'h99;
        upd_pred_taken = 1'b0; upd_pred_target = 30'h0;
        upd_valid = 1'b1; upd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.mispredict", 64'(mispredict), 64'd1);
            tick();
            lookup("stall", 30'h05, 1'b0, 1'b0, 30'h06);
            stats("stall", 12, 7);
        end
        update("stall_go", 30'h05, 1'b1, 30'h99, 1'b0, 30'h0, 1'b1);
        lookup("stall_go", 30'h05, 1'b1, 1'b1, 30'h99);
        stats("stall_go", 13, 8);

        inval = 1'b1;
        update("inval_upd", 30'h07, 1'b1, 30'h55, 1'b0, 30'h0, 1'b1);
        inval = 1'b0;
        lookup("inval_a", 30'h05, 1'b0, 1'b0, 30'h06);
        lookup("inval_b", 30'h20, 1'b0, 1'b0, 30'h21);
        lookup("inval_c", 30'h07, 1'b0, 1'b0, 30'h08);
        stats("inval", 14, 9);

        update("pre_rst", 30'h08, 1'b1, 30'h33, 1'b0, 30'h0, 1'b1);
        lookup("pre_rst", 30'h08, 1'b1, 1'b1, 30'h33);
        #1;
        nRST = 1'b0;
        #1;
        lookup("async_rst", 30'h08, 1'b0, 1'b0, 30'h09);
        stats("async_rst", 0, 0);
        tick();
        nRST = 1'b1;
        tick();

        lookup("wrap", 30'h3FFF_FFFF, 1'b0, 1'b0, 30'h0);

        for (int i = 0; i < 20; i++) begin
            update("sat", 30'h03, 1'b0, 30'h0, 1'b1, 30'h0, 1'b1);
        end
        stats("sat", 15, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
